// File: rtl/pll_lock_supervisor.sv
// PLL lock handshake sequencer: pulses the PLL steady-reset, waits for a stable
// synchronized lock (with timeout and bounded retries), then releases sys_rst.
module pll_lock_supervisor #(
    parameter int  STABLE_CYCLES = 1024,
    parameter int  LOCK_TIMEOUT  = 100000,
    parameter int  RST_PULSE     = 16,
    parameter int  MAX_RETRY     = 3,
    parameter int  CNT_W         = 20,
    localparam int RETRY_W       = $clog2(MAX_RETRY + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               retry_req,
    output logic               pll_stdy_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [7:0]         loss_cnt
);

    typedef enum logic [2:0] {
        S_RST,
        S_WAIT,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0]   PULSE_LAST = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0]   STB_LAST   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    state_t             state, state_n;
    logic               lock_meta, lock_sync;
    logic [CNT_W-1:0]   pulse_cnt, pulse_n;
    logic [CNT_W-1:0]   tmo_cnt, tmo_n;
    logic [CNT_W-1:0]   stb_cnt, stb_n;
    logic [RETRY_W-1:0] retry_n;
    logic [7:0]         loss_n;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // pll_locked comes from the PLL's own domain; only lock_sync may steer the FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RST;
            pulse_cnt <= '0;
            tmo_cnt   <= '0;
            stb_cnt   <= '0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            state     <= state_n;
            pulse_cnt <= pulse_n;
            tmo_cnt   <= tmo_n;
            stb_cnt   <= stb_n;
            retry_cnt <= retry_n;
            loss_cnt  <= loss_n;
        end
    end

    always_comb begin
        state_n = state;
        pulse_n = '0;
        tmo_n   = tmo_cnt;
        stb_n   = stb_cnt;
        retry_n = retry_cnt;
        loss_n  = loss_cnt;
        case (state)
            S_RST: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_n = S_WAIT;
                    tmo_n   = '0;
                end else begin
                    pulse_n = pulse_cnt + CNT_W'(1);
                end
            end
            S_WAIT, S_STABLE: begin
                tmo_n = tmo_cnt + CNT_W'(1);
                // Timeout overrides lock progress, even on the cycle STABLE would complete
                if (tmo_cnt == TMO_LAST) begin
                    if (retry_cnt == RETRY_LAST) begin
                        retry_n = RETRY_MAX;
                        state_n = S_FAULT;
                    end else begin
                        retry_n = retry_cnt + RETRY_W'(1);
                        state_n = S_RST;
                    end
                end else if (state == S_WAIT) begin
                    if (lock_sync) begin
                        state_n = S_STABLE;
                        stb_n   = '0;
                    end
                end else if (!lock_sync) begin
                    state_n = S_WAIT;
                end else if (stb_cnt == STB_LAST) begin
                    state_n = S_RUN;
                    retry_n = '0;
                end else begin
                    stb_n = stb_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                retry_n = '0;
                if (!lock_sync) begin
                    loss_n  = sat_inc8(loss_cnt);
                    state_n = S_RST;
                end
            end
            S_FAULT: begin
                if (retry_req) begin
                    retry_n = '0;
                    state_n = S_RST;
                end
            end
            default: state_n = S_RST;
        endcase
    end

    assign pll_stdy_rst = (state == S_RST);
    assign sys_rst      = (state != S_RUN);
    assign ready        = (state == S_RUN);
    assign fault        = (state == S_FAULT);

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized self-checking bench for pll_lock_supervisor against a timestamp-based
// reference model of the lock/reset sequencing rules.
module tb_pll_lock_supervisor;

    localparam int SC = 16;
    localparam int LT = 64;
    localparam int RP = 4;
    localparam int MR = 2;
    localparam int CW = 20;
    localparam logic [13:0] RST_VEC = 14'h3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       retry_req = 1'b0;
    logic       pll_stdy_rst, sys_rst, ready, fault;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [13:0] dut_vec;

    int errors = 0;
    int checks = 0;

    pll_lock_supervisor #(
        .STABLE_CYCLES(SC), .LOCK_TIMEOUT(LT), .RST_PULSE(RP), .MAX_RETRY(MR), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .retry_req(retry_req),
        .pll_stdy_rst(pll_stdy_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
    );

    always #5 clk = ~clk;

    assign dut_vec = {pll_stdy_rst, sys_rst, ready, fault, retry_cnt, loss_cnt};

    // Reference model: phases with entry timestamps; the lock it acts on is the
    // pll_locked value sampled two edges earlier.
    typedef enum {M_PULSE, M_SEEK, M_SETTLE, M_LIVE, M_DEAD} mode_t;
    mode_t mode;
    int    n, t_mode, t_seek, t_settle, retries, losses;
    bit    hist[$];

    function automatic void model_reset();
        mode = M_PULSE; n = 0; t_mode = -1; t_seek = 0; t_settle = 0;
        retries = 0; losses = 0; hist.delete();
    endfunction

    function automatic void model_step();
        bit seen;
        seen = (hist.size() >= 2) ? hist[hist.size() - 2] : 1'b0;
        case (mode)
            M_PULSE: if (n - t_mode == RP) begin mode = M_SEEK; t_seek = n; end
            M_SEEK, M_SETTLE: begin
                if (n - t_seek == LT) begin
                    if (retries + 1 == MR) begin retries = MR; mode = M_DEAD; end
                    else begin retries++; mode = M_PULSE; t_mode = n; end
                end else if (mode == M_SEEK) begin
                    if (seen) begin mode = M_SETTLE; t_settle = n; end
                end else if (!seen) mode = M_SEEK;
                else if (n - t_settle == SC) begin mode = M_LIVE; retries = 0; end
            end
            M_LIVE: if (!seen) begin
                losses = (losses < 255) ? losses + 1 : 255;
                mode = M_PULSE; t_mode = n;
            end
            M_DEAD: if (retry_req) begin retries = 0; mode = M_PULSE; t_mode = n; end
            default: ;
        endcase
        hist.push_back(pll_locked);
        if (hist.size() > 4) void'(hist.pop_front());
        n++;
    endfunction

    function automatic logic [13:0] exp_vec();
        return {mode == M_PULSE, mode != M_LIVE, mode == M_LIVE, mode == M_DEAD,
                retries[1:0], losses[7:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b0; retry_req = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        checks++;
        if (dut_vec !== RST_VEC) begin
            errors++; $display("FAIL reset_values got=%h exp=%h", dut_vec, RST_VEC);
        end
        rst = 1'b0;
    endtask

    task automatic test_release();
        for (int e = 0; e <= 40; e++) begin
            if (e == 10) pll_locked = 1'b1;
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL release e=%0d got=%h exp=%h", e, dut_vec, exp_vec());
            end
            if (e == 2) begin
                checks++;
                if (pll_stdy_rst !== 1'b1) begin
                    errors++; $display("FAIL pulse_high e=2 got=%b exp=1", pll_stdy_rst);
                end
            end
            if (e == 3) begin
                checks++;
                if (pll_stdy_rst !== 1'b0) begin
                    errors++; $display("FAIL pulse_end e=3 got=%b exp=0", pll_stdy_rst);
                end
            end
            if (e == 27) begin
                checks++;
                if (ready !== 1'b0) begin
                    errors++; $display("FAIL early_ready e=27 got=%b exp=0", ready);
                end
            end
            if (e == 28) begin
                checks++;
                if ({ready, sys_rst, retry_cnt} !== 4'b1000) begin
                    errors++; $display("FAIL release_edge28 got=%b exp=1000", {ready, sys_rst, retry_cnt});
                end
            end
        end
    endtask

    task automatic test_loss();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        checks++;
        if (sys_rst !== 1'b0) begin
            errors++; $display("FAIL loss_early got=%b exp=0", sys_rst);
        end
        tick();
        checks++;
        if ({sys_rst, ready, loss_cnt} !== {2'b10, 8'd1}) begin
            errors++; $display("FAIL loss_latency got=%h exp=%h", {sys_rst, ready, loss_cnt}, {2'b10, 8'd1});
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL relock i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL relock_ready got=%b exp=1", ready);
        end
    endtask

    task automatic test_timeout();
        int i;
        pll_locked = 1'b0;
        for (i = 0; i < 300 && fault !== 1'b1; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL timeout i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if ({fault, retry_cnt, pll_stdy_rst} !== 4'b1100) begin
            errors++; $display("FAIL fault_entry got=%b exp=1100", {fault, retry_cnt, pll_stdy_rst});
        end
        repeat (5) tick();
        checks++;
        if ({fault, pll_stdy_rst} !== 2'b10) begin
            errors++; $display("FAIL fault_sticky got=%b exp=10", {fault, pll_stdy_rst});
        end
        retry_req = 1'b1;
        tick();
        retry_req = 1'b0;
        checks++;
        if ({pll_stdy_rst, fault, retry_cnt} !== 4'b1000) begin
            errors++; $display("FAIL retry_req got=%b exp=1000", {pll_stdy_rst, fault, retry_cnt});
        end
    endtask

    task automatic test_glitch();
        bit seen_ready;
        int i;
        seen_ready = 1'b0;
        for (i = 0; i < 90; i++) begin
            pll_locked = (i % 10 != 9);
            tick();
            if (ready === 1'b1) seen_ready = 1'b1;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL glitch i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if ({seen_ready, retry_cnt} !== 3'b001) begin
            errors++; $display("FAIL glitch_result got=%b exp=001", {seen_ready, retry_cnt});
        end
        pll_locked = 1'b1;
        for (i = 0; i < 100 && ready !== 1'b1; i++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL glitch_relock i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL glitch_relock_bound got=%b exp=1", ready);
        end
    endtask

    task automatic test_saturate();
        int d, i;
        for (int k = 0; k < 300; k++) begin
            d = $urandom_range(1, 3);
            pll_locked = 1'b0;
            repeat (d) begin
                retry_req = ($urandom_range(0, 7) == 0);
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL sat_drop k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
                end
            end
            retry_req = 1'b0;
            pll_locked = 1'b1;
            repeat (2) tick();
            for (i = 0; i < 100 && ready !== 1'b1; i++) begin
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL sat_relock k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
                end
            end
            if (ready !== 1'b1) begin
                checks++; errors++;
                $display("FAIL sat_relock_bound k=%0d got=%b exp=1", k, ready);
            end
        end
        checks++;
        if (loss_cnt !== 8'd255) begin
            errors++; $display("FAIL loss_saturate got=%0d exp=255", loss_cnt);
        end
    endtask

    task automatic test_random();
        int len;
        bit val;
        for (int seg = 0; seg < 150; seg++) begin
            len = $urandom_range(1, 40);
            val = ($urandom_range(0, 9) < 7);
            for (int c = 0; c < len; c++) begin
                pll_locked = val;
                retry_req = ($urandom_range(0, 15) == 0);
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL random seg=%0d got=%h exp=%h", seg, dut_vec, exp_vec());
                end
            end
        end
        retry_req = 1'b0;
    endtask

    task automatic test_async_reset();
        int i;
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== RST_VEC) begin
            errors++; $display("FAIL async_rst_random got=%h exp=%h", dut_vec, RST_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
        pll_locked = 1'b1;
        for (i = 0; i < 50 && mode != M_SETTLE; i++) tick();
        repeat (5) tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL mid_stable got=%h exp=%h", dut_vec, exp_vec());
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== RST_VEC) begin
            errors++; $display("FAIL async_rst_stable got=%h exp=%h", dut_vec, RST_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                pll_locked = 1'b0;
                tick();
                pll_locked = 1'b1;
                repeat (2) tick();
            end
            for (i = 0; i < 80 && ready !== 1'b1; i++) tick();
            checks++;
            if (dut_vec !== exp_vec() || ready !== 1'b1) begin
                errors++; $display("FAIL run_loss k=%0d got=%h exp=%h", k, dut_vec, exp_vec());
            end
        end
        checks++;
        if (loss_cnt !== 8'd5) begin
            errors++; $display("FAIL loss_five got=%0d exp=5", loss_cnt);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_vec !== RST_VEC) begin
            errors++; $display("FAIL async_rst_run got=%h exp=%h", dut_vec, RST_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
        pll_locked = 1'b0;
        repeat (3) tick();
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL post_rst got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_release();
        test_loss();
        test_timeout();
        test_glitch();
        test_saturate();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
